// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: opcodes, the
// 4-bit state encoding, datapath select codes and the control-word struct.
package mc_ctrl_pkg;

   // RV32I major opcodes (IR[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // State encoding; S_IF must stay 0 so the async clear lands in fetch
   localparam logic [3:0] S_IF      = 4'd0;
   localparam logic [3:0] S_ID      = 4'd1;
   localparam logic [3:0] S_EX_ALU  = 4'd2;
   localparam logic [3:0] S_EX_ADDR = 4'd3;
   localparam logic [3:0] S_MEM_RD  = 4'd4;
   localparam logic [3:0] S_MEM_WR  = 4'd5;
   localparam logic [3:0] S_EX_BR   = 4'd6;
   localparam logic [3:0] S_EX_JAL  = 4'd7;
   localparam logic [3:0] S_EX_JALR = 4'd8;
   localparam logic [3:0] S_WB_ALU  = 4'd9;
   localparam logic [3:0] S_WB_MEM  = 4'd10;
   localparam logic [3:0] S_WB_LUI  = 4'd11;
   localparam logic [3:0] S_HALT    = 4'd12;

   // ALU operand A mux
   localparam logic [1:0] SRCA_A     = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   // ALU operand B mux (MUX_6)
   localparam logic [2:0] SRCB_B     = 3'b000;
   localparam logic [2:0] SRCB_FOUR  = 3'b001;
   localparam logic [2:0] SRCB_IMM   = 3'b010;

   // ALU operation class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_FUNCT = 2'b01;
   localparam logic [1:0] ALUOP_BR    = 2'b10;

   // Register-file write-back mux (MUX_6)
   localparam logic [2:0] WB_ALUOUT = 3'b000;
   localparam logic [2:0] WB_MDR    = 3'b001;
   localparam logic [2:0] WB_PC     = 3'b010;
   localparam logic [2:0] WB_IMM    = 3'b011;

   // Instruction class produced by the main decoder
   typedef enum logic [3:0] {
      CLS_OP,
      CLS_OPIMM,
      CLS_AUIPC,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI,
      CLS_SYSTEM,
      CLS_ILLEGAL
   } instr_cls_e;

   // Complete control word driven to the datapath
   typedef struct packed {
      logic       i_mem_rd;
      logic       d_mem_rd;
      logic       d_mem_wr;
      logic       pc_write;
      logic       ir_write;
      logic       rs_write;
      logic       aluout_write;
      logic       mdr_write;
      logic       rf_write;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic [1:0] alu_op;
      logic       pc_sel;
      logic [2:0] wb_sel;
      logic       halted;
   } ctrl_t;

   // All-inactive control word: every enable low, every select at code 0
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

endpackage

// File: rtl/mc_main_decoder.sv
// Main opcode decoder: classifies OPCODE and supplies the state that
// follows S_ID. Purely combinational.
import mc_ctrl_pkg::*;

module mc_main_decoder #(
   parameter int unsigned HALT_ON_ILLEGAL = 1
) (
   input  logic [6:0]  opcode_i,
   output instr_cls_e  cls_o,
   output logic [3:0]  id_next_o
);

   // Opcode to instruction class and post-decode state
   always_comb begin
      cls_o     = CLS_ILLEGAL;
      id_next_o = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_IF;
      case (opcode_i)
         OPC_OP:     begin cls_o = CLS_OP;     id_next_o = S_EX_ALU;  end
         OPC_OPIMM:  begin cls_o = CLS_OPIMM;  id_next_o = S_EX_ALU;  end
         OPC_AUIPC:  begin cls_o = CLS_AUIPC;  id_next_o = S_EX_ALU;  end
         OPC_LOAD:   begin cls_o = CLS_LOAD;   id_next_o = S_EX_ADDR; end
         OPC_STORE:  begin cls_o = CLS_STORE;  id_next_o = S_EX_ADDR; end
         OPC_BRANCH: begin cls_o = CLS_BRANCH; id_next_o = S_EX_BR;   end
         OPC_JAL:    begin cls_o = CLS_JAL;    id_next_o = S_EX_JAL;  end
         OPC_JALR:   begin cls_o = CLS_JALR;   id_next_o = S_EX_JALR; end
         OPC_LUI:    begin cls_o = CLS_LUI;    id_next_o = S_WB_LUI;  end
         OPC_SYSTEM: begin cls_o = CLS_SYSTEM; id_next_o = S_HALT;    end
         default:    ;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit. A per-instruction state machine drives
// all datapath enables and mux selects. Outputs are decoded from the state
// register (updated on posedge) so they are stable across the datapath's
// negedge capture.
// Optional feature macro: MC_PERF_CNT_EN adds cycle/retired-instruction
// counters; without it CYCLE_CNT and INSTR_CNT are tied to zero.
import mc_ctrl_pkg::*;

module mc_control_fsm #(
   parameter int unsigned HALT_ON_ILLEGAL = 1,
   parameter int unsigned PERF_W          = 32
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [6:0]        OPCODE,
   input  logic [2:0]        FUNCT3,
   input  logic              BR_TAKEN,
   input  logic              I_READY,
   input  logic              D_READY,
   output logic              I_MEM_RD,
   output logic              D_MEM_RD,
   output logic              D_MEM_WR,
   output logic              PC_WRITE,
   output logic              IR_WRITE,
   output logic              RS_WRITE,
   output logic              ALUOUT_WRITE,
   output logic              MDR_WRITE,
   output logic              RF_WRITE,
   output logic [1:0]        ALU_SRC_A,
   output logic [2:0]        ALU_SRC_B,
   output logic [1:0]        ALU_OP,
   output logic              PC_SEL,
   output logic [2:0]        WB_SEL,
   output logic              HALTED,
   output logic [PERF_W-1:0] CYCLE_CNT,
   output logic [PERF_W-1:0] INSTR_CNT
);

   logic [3:0] state_q, state_d;
   instr_cls_e cls_q, cls_d;
   instr_cls_e dec_cls;
   logic [3:0] dec_next;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;

   // FUNCT3 is consumed by the datapath ALU decoder, not by this FSM
   logic funct3_unused;
   assign funct3_unused = ^FUNCT3;

   mc_main_decoder #(
      .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
   ) u_dec (
      .opcode_i  (OPCODE),
      .cls_o     (dec_cls),
      .id_next_o (dec_next)
   );

   // State and latched instruction class; class is captured leaving S_ID so
   // later states do not depend on IR staying untouched
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_IF;
         cls_q   <= CLS_ILLEGAL;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

   // Next-state and per-state control word
   always_comb begin
      ctrl    = ctrl_idle();
      state_d = state_q;
      cls_d   = cls_q;
      case (state_q)
         S_IF: begin
            ctrl.i_mem_rd  = 1'b1;
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_write  = I_READY;
            ctrl.ir_write  = I_READY;
            if (I_READY) state_d = S_ID;
         end
         S_ID: begin
            // Branch/jump target precomputed as OLD_PC + IMM
            ctrl.rs_write     = 1'b1;
            ctrl.aluout_write = 1'b1;
            ctrl.alu_src_a    = SRCA_OLDPC;
            ctrl.alu_src_b    = SRCB_IMM;
            ctrl.alu_op       = ALUOP_ADD;
            state_d           = dec_next;
            cls_d             = dec_cls;
         end
         S_EX_ALU: begin
            ctrl.alu_src_a    = (cls_q == CLS_AUIPC) ? SRCA_OLDPC : SRCA_A;
            ctrl.alu_src_b    = (cls_q == CLS_OP) ? SRCB_B : SRCB_IMM;
            ctrl.alu_op       = ((cls_q == CLS_OP) || (cls_q == CLS_OPIMM)) ?
                                ALUOP_FUNCT : ALUOP_ADD;
            ctrl.aluout_write = 1'b1;
            state_d           = S_WB_ALU;
         end
         S_EX_ADDR: begin
            ctrl.alu_src_a    = SRCA_A;
            ctrl.alu_src_b    = SRCB_IMM;
            ctrl.alu_op       = ALUOP_ADD;
            ctrl.aluout_write = 1'b1;
            state_d           = (cls_q == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            ctrl.d_mem_rd  = 1'b1;
            ctrl.mdr_write = D_READY;
            if (D_READY) state_d = S_WB_MEM;
         end
         S_MEM_WR: begin
            ctrl.d_mem_wr = 1'b1;
            if (D_READY) state_d = S_IF;
         end
         S_EX_BR: begin
            ctrl.alu_src_a = SRCA_A;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_BR;
            ctrl.pc_write  = BR_TAKEN;
            ctrl.pc_sel    = 1'b1;
            state_d        = S_IF;
         end
         S_EX_JAL: begin
            ctrl.rf_write = 1'b1;
            ctrl.wb_sel   = WB_PC;
            ctrl.pc_write = 1'b1;
            ctrl.pc_sel   = 1'b1;
            state_d       = S_IF;
         end
         S_EX_JALR: begin
            // Link and PC update share an edge: RF sees the old PC (PC+4)
            ctrl.alu_src_a = SRCA_A;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.rf_write  = 1'b1;
            ctrl.wb_sel    = WB_PC;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_sel    = 1'b0;
            state_d        = S_IF;
         end
         S_WB_ALU: begin
            ctrl.rf_write = 1'b1;
            ctrl.wb_sel   = WB_ALUOUT;
            state_d       = S_IF;
         end
         S_WB_MEM: begin
            ctrl.rf_write = 1'b1;
            ctrl.wb_sel   = WB_MDR;
            state_d       = S_IF;
         end
         S_WB_LUI: begin
            ctrl.rf_write = 1'b1;
            ctrl.wb_sel   = WB_IMM;
            state_d       = S_IF;
         end
         S_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: begin
            // Unused encodings recover to fetch
            state_d = S_IF;
         end
      endcase
   end

   // Reset forces every output low at once, aborting any memory request
   always_comb begin
      ctrl_out = RSTn ? ctrl : ctrl_idle();
   end

   assign I_MEM_RD     = ctrl_out.i_mem_rd;
   assign D_MEM_RD     = ctrl_out.d_mem_rd;
   assign D_MEM_WR     = ctrl_out.d_mem_wr;
   assign PC_WRITE     = ctrl_out.pc_write;
   assign IR_WRITE     = ctrl_out.ir_write;
   assign RS_WRITE     = ctrl_out.rs_write;
   assign ALUOUT_WRITE = ctrl_out.aluout_write;
   assign MDR_WRITE    = ctrl_out.mdr_write;
   assign RF_WRITE     = ctrl_out.rf_write;
   assign ALU_SRC_A    = ctrl_out.alu_src_a;
   assign ALU_SRC_B    = ctrl_out.alu_src_b;
   assign ALU_OP       = ctrl_out.alu_op;
   assign PC_SEL       = ctrl_out.pc_sel;
   assign WB_SEL       = ctrl_out.wb_sel;
   assign HALTED       = ctrl_out.halted;

`ifdef MC_PERF_CNT_EN
   localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   logic [PERF_W-1:0] cycle_q;
   logic [PERF_W-1:0] instr_q;

   // Cycle counter freezes in halt; instruction counter bumps on return to fetch
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if (state_q != S_HALT) cycle_q <= cycle_q + PERF_ONE;
         if ((state_d == S_IF) && (state_q != S_IF)) instr_q <= instr_q + PERF_ONE;
      end
   end

   assign CYCLE_CNT = cycle_q;
   assign INSTR_CNT = instr_q;
`else
   assign CYCLE_CNT = '0;
   assign INSTR_CNT = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a phase-string model of each instruction's
// lifetime predicts every output each cycle; directed sequences with literal
// expectations pin the model, then randomized opcodes/ready/branch inputs.
module tb_mc_control_fsm;

   localparam int HOI = 0;
   localparam int PW  = 32;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [6:0]    OPCODE = '0;
   logic [2:0]    FUNCT3 = '0;
   logic          BR_TAKEN = 1'b0, I_READY = 1'b0, D_READY = 1'b0;
   logic          I_MEM_RD, D_MEM_RD, D_MEM_WR, PC_WRITE, IR_WRITE, RS_WRITE;
   logic          ALUOUT_WRITE, MDR_WRITE, RF_WRITE, PC_SEL, HALTED;
   logic [1:0]    ALU_SRC_A, ALU_OP;
   logic [2:0]    ALU_SRC_B, WB_SEL;
   logic [PW-1:0] CYCLE_CNT, INSTR_CNT;

   mc_control_fsm #(.HALT_ON_ILLEGAL(HOI), .PERF_W(PW)) dut (
      .CLK(CLK), .RSTn(RSTn), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
      .BR_TAKEN(BR_TAKEN), .I_READY(I_READY), .D_READY(D_READY),
      .I_MEM_RD(I_MEM_RD), .D_MEM_RD(D_MEM_RD), .D_MEM_WR(D_MEM_WR),
      .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .RS_WRITE(RS_WRITE),
      .ALUOUT_WRITE(ALUOUT_WRITE), .MDR_WRITE(MDR_WRITE), .RF_WRITE(RF_WRITE),
      .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
      .PC_SEL(PC_SEL), .WB_SEL(WB_SEL), .HALTED(HALTED),
      .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic imr, dmr, dmw, pcw, irw, rsw, aow, mdw, rfw;
      logic [1:0] srca;
      logic [2:0] srcb;
      logic [1:0] aluop;
      logic pcsel;
      logic [2:0] wb;
      logic halted;
   } outs_t;

   outs_t act;
   assign act = {I_MEM_RD, D_MEM_RD, D_MEM_WR, PC_WRITE, IR_WRITE, RS_WRITE,
                 ALUOUT_WRITE, MDR_WRITE, RF_WRITE, ALU_SRC_A, ALU_SRC_B,
                 ALU_OP, PC_SEL, WB_SEL, HALTED};

`ifdef MC_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [6:0]  cur_op = '0;
   bit          have_op = 1'b0;
   int          pos = 0;
   int unsigned m_cyc = 0, m_ins = 0;
   logic [6:0]  op_q[$];

   // Each instruction is a string of phases; F/M/S wait on their ready, H never ends
   function automatic string seq_for(input logic [6:0] op);
      case (op)
         7'b0110011, 7'b0010011, 7'b0010111: return "FDEW";
         7'b0000011: return "FDAMR";
         7'b0100011: return "FDAS";
         7'b1100011: return "FDB";
         7'b1101111: return "FDJ";
         7'b1100111: return "FDK";
         7'b0110111: return "FDL";
         7'b1110011: return "FDH";
         default:    return (HOI != 0) ? "FDH" : "FD";
      endcase
   endfunction

   function automatic logic [6:0] pick_op();
      logic [6:0] ops [0:8];
      int unsigned r;
      ops = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
      if (op_q.size() > 0) return op_q.pop_front();
      r = $urandom_range(0, 99);
      if (r < 2)  return 7'b1110011;
      if (r < 5)  return 7'b0000000;
      if (r < 8)  return 7'b1111111;
      return ops[r % 9];
   endfunction

   function automatic outs_t expect_outs(input byte ph, input logic [6:0] op,
                                         input logic ir, input logic dr, input logic bt);
      outs_t o;
      o = '0;
      case (ph)
         "F": begin o.imr = 1; o.srca = 2'b01; o.srcb = 3'b001; o.pcw = ir; o.irw = ir; end
         "D": begin o.rsw = 1; o.aow = 1; o.srca = 2'b10; o.srcb = 3'b010; end
         "E": begin
            o.aow   = 1;
            o.srca  = (op == 7'b0010111) ? 2'b10 : 2'b00;
            o.srcb  = (op == 7'b0110011) ? 3'b000 : 3'b010;
            o.aluop = (op == 7'b0110011 || op == 7'b0010011) ? 2'b01 : 2'b00;
         end
         "W": begin o.rfw = 1; o.wb = 3'b000; end
         "A": begin o.aow = 1; o.srcb = 3'b010; end
         "M": begin o.dmr = 1; o.mdw = dr; end
         "R": begin o.rfw = 1; o.wb = 3'b001; end
         "S": begin o.dmw = 1; end
         "B": begin o.aluop = 2'b10; o.pcw = bt; o.pcsel = 1; end
         "J": begin o.rfw = 1; o.wb = 3'b010; o.pcw = 1; o.pcsel = 1; end
         "K": begin o.srcb = 3'b010; o.rfw = 1; o.wb = 3'b010; o.pcw = 1; end
         "L": begin o.rfw = 1; o.wb = 3'b011; end
         "H": begin o.halted = 1; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
      end
   endtask

   // Drive one cycle's inputs, then at the negedge compare all outputs with the model
   task automatic drive(input logic ir, input logic dr, input logic bt);
      outs_t e;
      string s;
      if (RSTn && !have_op) begin cur_op = pick_op(); have_op = 1'b1; end
      OPCODE   = have_op ? cur_op : 7'($urandom);
      FUNCT3   = 3'($urandom);
      I_READY  = ir;
      D_READY  = dr;
      BR_TAKEN = bt;
      #4;
      s = seq_for(cur_op);
      e = RSTn ? expect_outs(s[pos], cur_op, ir, dr, bt) : outs_t'('0);
      n_cmp++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL outs: got %h expected %h (phase %s op %b) at %0t",
                  act, e, s.substr(pos, pos), cur_op, $time);
      end
      chk("cycle_cnt", CYCLE_CNT, (PERF && RSTn) ? m_cyc : 0);
      chk("instr_cnt", INSTR_CNT, (PERF && RSTn) ? m_ins : 0);
   endtask

   // Advance the model across the next posedge
   task automatic adv();
      string s;
      byte   ph;
      bit    hold;
      @(posedge CLK);
      if (!RSTn) begin
         pos = 0; have_op = 1'b0; m_cyc = 0; m_ins = 0;
      end else begin
         s    = seq_for(cur_op);
         ph   = s[pos];
         hold = (ph == "F" && !I_READY) || ((ph == "M" || ph == "S") && !D_READY) || (ph == "H");
         if (ph != "H") m_cyc++;
         if (!hold) begin
            pos++;
            if (pos == s.len()) begin pos = 0; have_op = 1'b0; m_ins++; end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      chk("rst_outs_zero", 32'(act), 0);
      adv();
      RSTn = 1'b1;
   endtask

   initial begin
      int    rst_hold;
      int    halt_cycles;
      string s;
      logic [31:0] c0;
      rst_hold = 0;
      halt_cycles = 0;

      op_q.push_back(7'b0110011);
      op_q.push_back(7'b0000011);
      op_q.push_back(7'b1100011);
      op_q.push_back(7'b1100011);
      op_q.push_back(7'b1100111);
      op_q.push_back(7'b0000000);
      #1;
      do_reset();

      // ADD: IF ID EX_ALU WB_ALU
      drive(1, 0, 0); chk("add_if_imr", 32'(I_MEM_RD), 1); chk("add_if_irw", 32'(IR_WRITE), 1); adv();
      drive(0, 0, 0); chk("add_id_rsw", 32'(RS_WRITE), 1); chk("add_id_rfw", 32'(RF_WRITE), 0); adv();
      drive(0, 0, 0); chk("add_ex_aluop", 32'(ALU_OP), 1); chk("add_ex_rfw", 32'(RF_WRITE), 0); adv();
      drive(0, 0, 0); chk("add_wb_rfw", 32'(RF_WRITE), 1); chk("add_wb_sel", 32'(WB_SEL), 0); adv();
      // LW with D_READY low three cycles
      drive(1, 0, 0); chk("lw_instr_cnt", INSTR_CNT, PERF ? 1 : 0); chk("lw_cycle_cnt", CYCLE_CNT, PERF ? 4 : 0); adv();
      drive(0, 0, 0); adv();
      drive(0, 1, 0); chk("lw_addr_aow", 32'(ALUOUT_WRITE), 1); adv();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0); chk("lw_wait_dmr", 32'(D_MEM_RD), 1); chk("lw_wait_mdw", 32'(MDR_WRITE), 0); adv();
      end
      drive(0, 1, 0); chk("lw_last_mdw", 32'(MDR_WRITE), 1); adv();
      drive(0, 0, 0); chk("lw_wb_sel", 32'(WB_SEL), 1); chk("lw_wb_rfw", 32'(RF_WRITE), 1); adv();
      // BEQ taken, then not taken
      drive(1, 0, 0); adv(); drive(0, 0, 0); adv();
      drive(0, 0, 1); chk("beq_t_pcw", 32'(PC_WRITE), 1); chk("beq_t_pcsel", 32'(PC_SEL), 1); adv();
      drive(1, 0, 0); adv(); drive(0, 0, 0); adv();
      drive(0, 0, 0); chk("beq_nt_pcw", 32'(PC_WRITE), 0); adv();
      // JALR
      drive(1, 0, 0); chk("beq_back_if", 32'(I_MEM_RD), 1); adv(); drive(0, 0, 0); adv();
      drive(0, 0, 0);
      chk("jalr_rfw", 32'(RF_WRITE), 1); chk("jalr_wb", 32'(WB_SEL), 2);
      chk("jalr_pcw", 32'(PC_WRITE), 1); chk("jalr_pcsel", 32'(PC_SEL), 0);
      adv();
      // Opcode 0000000 treated as NOP
      drive(1, 0, 0); adv(); drive(0, 0, 0); adv();
      drive(0, 0, 0);
      chk("ill_back_if", 32'(I_MEM_RD), 1); chk("ill_not_halt", 32'(HALTED), 0);
      chk("ill_instr_cnt", INSTR_CNT, PERF ? 6 : 0); chk("ill_cycle_cnt", CYCLE_CNT, PERF ? 23 : 0);
      adv();

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if (!RSTn) begin
            if (rst_hold == 0) RSTn = 1'b1; else rst_hold--;
         end else if (halt_cycles > 4 || $urandom_range(0, 249) == 0) begin
            RSTn = 1'b0;
            rst_hold = $urandom_range(0, 2);
            halt_cycles = 0;
         end
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom));
         adv();
         s = seq_for(cur_op);
         if (RSTn && have_op && s[pos] == "H") halt_cycles++;
      end

      // ECALL halts and freezes the cycle counter
      do_reset();
      op_q.push_back(7'b1110011);
      drive(1, 0, 0); adv(); drive(0, 0, 0); adv();
      drive(1, 1, 1); chk("ecall_halted", 32'(HALTED), 1); c0 = CYCLE_CNT; adv();
      for (int k = 0; k < 4; k++) begin drive(1, 1, 1); adv(); end
      drive(1, 1, 1);
      chk("halt_held", 32'(HALTED), 1); chk("halt_imr", 32'(I_MEM_RD), 0);
      chk("halt_cyc_frozen", CYCLE_CNT, PERF ? 2 : 0);
      chk("halt_cyc_same", CYCLE_CNT, c0);
      adv();

      // Reset pulsed during a store drops D_MEM_WR immediately
      do_reset();
      op_q.push_back(7'b0100011);
      drive(1, 0, 0); adv(); drive(0, 0, 0); adv(); drive(0, 0, 0); adv();
      drive(0, 0, 0); chk("st_dmw", 32'(D_MEM_WR), 1); adv();
      RSTn = 1'b0;
      #1;
      chk("st_rst_dmw", 32'(D_MEM_WR), 0);
      chk("st_rst_outs", 32'(act), 0);
      #3;
      adv();
      RSTn = 1'b1;
      drive(0, 0, 0); chk("post_rst_if", 32'(I_MEM_RD), 1); adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
